// File: rtl/floo_mcast_route_fork_pkg.sv
// Shared types for the multicast route-select/fork stage: directions, XY ids, flit header.
package floo_mcast_route_fork_pkg;

    localparam int NUM_ROUTES = 5;
    localparam int XW = 3;
    localparam int YW = 3;
    localparam int PAYLOAD_W = 16;
    localparam int REP_W = $clog2(NUM_ROUTES + 1);

    typedef enum logic [2:0] {
        Eject = 3'd0,
        South = 3'd1,
        West  = 3'd2,
        North = 3'd3,
        East  = 3'd4
    } route_direction_e;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } id_t;

    // mask is typed like dst_id so per-axis wildcard bits line up
    typedef struct packed {
        logic last;
        logic mcast_flag;
        id_t  mask;
        id_t  dst_id;
    } hdr_t;

    typedef struct packed {
        hdr_t                 hdr;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    function automatic logic [REP_W-1:0] popcount(input logic [NUM_ROUTES-1:0] v);
        logic [REP_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_ROUTES; i++) begin
            n = n + REP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/floo_mcast_xy_decode.sv
// Combinational XY output-set decode: unicast dimension-order route or multicast tree branches.
module floo_mcast_xy_decode
    import floo_mcast_route_fork_pkg::*;
#(
    parameter int   NumRoutes = 5,
    parameter int   InPort    = 0,
    parameter logic EnMcast   = 1'b1
) (
    input  id_t                  dst,
    input  id_t                  mask,
    input  logic                 mcast_flag,
    input  id_t                  xy_id,
    output logic [NumRoutes-1:0] sel
);

    logic [XW-1:0] lo_x, hi_x;
    logic [YW-1:0] lo_y, hi_y;
    logic          hit_x, hit_y;

    assign lo_x  = dst.x & ~mask.x;
    assign hi_x  = dst.x | mask.x;
    assign lo_y  = dst.y & ~mask.y;
    assign hi_y  = dst.y | mask.y;
    assign hit_x = ((xy_id.x ^ dst.x) & ~mask.x) == '0;
    assign hit_y = ((xy_id.y ^ dst.y) & ~mask.y) == '0;

    // Tree branches: X spreads only from Eject or straight-through, Y never turns back
    localparam logic AllowWest  = (InPort == int'(Eject)) || (InPort == int'(East));
    localparam logic AllowEast  = (InPort == int'(Eject)) || (InPort == int'(West));
    localparam logic AllowSouth = (InPort != int'(South));
    localparam logic AllowNorth = (InPort != int'(North));

    always_comb begin
        sel = '0;
        if (EnMcast && mcast_flag) begin
            if (AllowWest && (lo_x < xy_id.x)) sel[int'(West)] = 1'b1;
            if (AllowEast && (hi_x > xy_id.x)) sel[int'(East)] = 1'b1;
            if (hit_x) begin
                if (AllowSouth && (lo_y < xy_id.y)) sel[int'(South)] = 1'b1;
                if (AllowNorth && (hi_y > xy_id.y)) sel[int'(North)] = 1'b1;
                if (hit_y)                          sel[int'(Eject)] = 1'b1;
            end
        end else begin
            if (dst == xy_id) begin
                sel[int'(Eject)] = 1'b1;
            end else if (dst.x == xy_id.x) begin
                if (dst.y < xy_id.y) sel[int'(South)] = 1'b1;
                else                 sel[int'(North)] = 1'b1;
            end else begin
                if (dst.x < xy_id.x) sel[int'(West)] = 1'b1;
                else                 sel[int'(East)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/floo_mcast_route_fork.sv
// Route-select and fork stage: per-output handshakes, input released once every copy is taken.
module floo_mcast_route_fork
    import floo_mcast_route_fork_pkg::*;
#(
    parameter int   NumRoutes   = 5,
    parameter int   InPort      = 0,
    parameter logic EnMcast     = 1'b1,
    parameter logic LockRouting = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  id_t                               xy_id_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  flit_t                             channel_i,
    output logic  [NumRoutes-1:0]             valid_o,
    input  logic  [NumRoutes-1:0]             ready_i,
    output flit_t [NumRoutes-1:0]             channel_o,
    output logic  [NumRoutes-1:0]             route_sel_o,
    output logic  [$clog2(NumRoutes+1)-1:0]   rep_coeff_o,
    output logic                              drop_o
);

    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    logic [0:0]           state_q;
    logic [NumRoutes-1:0] route_q;
    logic [NumRoutes-1:0] sent_q;
    logic [NumRoutes-1:0] dec_sel;
    logic [NumRoutes-1:0] sel;
    logic [NumRoutes-1:0] acc;
    logic                 done;

    floo_mcast_xy_decode #(
        .NumRoutes (NumRoutes),
        .InPort    (InPort),
        .EnMcast   (EnMcast)
    ) i_decode (
        .dst        (channel_i.hdr.dst_id),
        .mask       (channel_i.hdr.mask),
        .mcast_flag (channel_i.hdr.mcast_flag),
        .xy_id      (xy_id_i),
        .sel        (dec_sel)
    );

    assign sel  = (LockRouting && (state_q == LOCKED)) ? route_q : dec_sel;
    assign acc  = valid_o & ready_i;
    assign done = valid_i && (((sent_q | acc) & sel) == sel);

    // Copies already taken drop out of valid_o; ready_i never feeds valid_o
    assign valid_o     = {NumRoutes{valid_i}} & sel & ~sent_q;
    assign ready_o     = done;
    assign drop_o      = done && (sel == '0);
    assign route_sel_o = valid_i ? sel : '0;

    always_comb begin
        rep_coeff_o = '0;
        for (int i = 0; i < NumRoutes; i++) begin
            rep_coeff_o = rep_coeff_o + ($clog2(NumRoutes+1))'(route_sel_o[i]);
        end
    end

    for (genvar g = 0; g < NumRoutes; g++) begin : gen_out
        assign channel_o[g] = channel_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sent_q  <= '0;
            route_q <= '0;
            state_q <= UNLOCKED;
        end else begin
            if (done) sent_q <= '0;
            else      sent_q <= sent_q | acc;
            if (LockRouting) begin
                unique case (state_q)
                    UNLOCKED: if (done && !channel_i.hdr.last) begin
                        route_q <= sel;
                        state_q <= LOCKED;
                    end
                    LOCKED: if (done && channel_i.hdr.last) begin
                        state_q <= UNLOCKED;
                    end
                    default: state_q <= UNLOCKED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_floo_mcast_route_fork.sv
// Directed bench for the route fork: three instances (InPort Eject/West/North) share stimulus.
module tb_floo_mcast_route_fork;
    import floo_mcast_route_fork_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    id_t xy;
    logic valid;
    logic [4:0] rdy;
    flit_t chan;

    logic ro, ro_w, ro_n;
    logic [4:0] vo, vo_w, vo_n;
    flit_t [4:0] co, co_w, co_n;
    logic [4:0] rs, rs_w, rs_n;
    logic [2:0] rc, rc_w, rc_n;
    logic dr, dr_w, dr_n;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    floo_mcast_route_fork #(.InPort(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .xy_id_i(xy), .valid_i(valid), .ready_o(ro),
        .channel_i(chan), .valid_o(vo), .ready_i(rdy), .channel_o(co),
        .route_sel_o(rs), .rep_coeff_o(rc), .drop_o(dr));

    floo_mcast_route_fork #(.InPort(2)) dut_w (
        .clk_i(clk), .rst_ni(rst_n), .xy_id_i(xy), .valid_i(valid), .ready_o(ro_w),
        .channel_i(chan), .valid_o(vo_w), .ready_i(rdy), .channel_o(co_w),
        .route_sel_o(rs_w), .rep_coeff_o(rc_w), .drop_o(dr_w));

    floo_mcast_route_fork #(.InPort(3)) dut_n (
        .clk_i(clk), .rst_ni(rst_n), .xy_id_i(xy), .valid_i(valid), .ready_o(ro_n),
        .channel_i(chan), .valid_o(vo_n), .ready_i(rdy), .channel_o(co_n),
        .route_sel_o(rs_n), .rep_coeff_o(rc_n), .drop_o(dr_n));

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        rdy   = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic set_flit(input logic [2:0] dx, input logic [2:0] dy,
                            input logic [2:0] mx, input logic [2:0] my,
                            input logic mc, input logic last, input logic [15:0] pl);
        chan = '0;
        chan.hdr.dst_id.x   = dx;
        chan.hdr.dst_id.y   = dy;
        chan.hdr.mask.x     = mx;
        chan.hdr.mask.y     = my;
        chan.hdr.mcast_flag = mc;
        chan.hdr.last       = last;
        chan.payload        = pl;
    endtask

    task automatic test_reset();
        apply_reset();
        #3;
        total++; if (vo !== 5'b00000) begin bad++; $display("FAIL reset_valid_o got=%b exp=00000", vo); end
        total++; if (ro !== 1'b0) begin bad++; $display("FAIL reset_ready_o got=%b exp=0", ro); end
        total++; if (dr !== 1'b0) begin bad++; $display("FAIL reset_drop_o got=%b exp=0", dr); end
        total++; if (rs !== 5'b00000) begin bad++; $display("FAIL reset_route_sel got=%b exp=00000", rs); end
        total++; if (rc !== 3'd0) begin bad++; $display("FAIL reset_rep_coeff got=%0d exp=0", rc); end
    endtask

    task automatic test_unicast();
        apply_reset();
        set_flit(3'd2, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 16'hA5C3);
        valid = 1'b1;
        rdy   = 5'b00001;
        #3;
        total++; if (vo !== 5'b00001) begin bad++; $display("FAIL uni_eject_valid got=%b exp=00001", vo); end
        total++; if (rc !== 3'd1) begin bad++; $display("FAIL uni_eject_rep got=%0d exp=1", rc); end
        total++; if (ro !== 1'b1) begin bad++; $display("FAIL uni_eject_ready got=%b exp=1", ro); end
        total++; if (dr !== 1'b0) begin bad++; $display("FAIL uni_eject_drop got=%b exp=0", dr); end
        total++; if (co[0] !== chan) begin bad++; $display("FAIL uni_channel_o got=%h exp=%h", co[0], chan); end
        next_cycle();
        // Unicast to the north-west of local: x differs, so West first
        set_flit(3'd1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0001);
        rdy = 5'b00000;
        #3;
        total++; if (vo !== 5'b00100) begin bad++; $display("FAIL uni_west_valid got=%b exp=00100", vo); end
        total++; if (ro !== 1'b0) begin bad++; $display("FAIL uni_west_ready got=%b exp=0", ro); end
        // Same column, lower y: South
        set_flit(3'd2, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0002);
        #1;
        total++; if (vo !== 5'b00010) begin bad++; $display("FAIL uni_south_valid got=%b exp=00010", vo); end
        // mcast_flag ignored mask-wise: unicast with mask set still single port North
        set_flit(3'd2, 3'd5, 3'd3, 3'd3, 1'b0, 1'b1, 16'h0003);
        #1;
        total++; if (vo !== 5'b01000) begin bad++; $display("FAIL uni_north_valid got=%b exp=01000", vo); end
        valid = 1'b0;
    endtask

    task automatic test_mcast();
        apply_reset();
        set_flit(3'd0, 3'd2, 3'd3, 3'd0, 1'b1, 1'b1, 16'h1234);
        valid = 1'b1;
        rdy   = 5'b00000;
        #3;
        total++; if (vo !== 5'b10101) begin bad++; $display("FAIL mc_eject_valid got=%b exp=10101", vo); end
        total++; if (rc !== 3'd3) begin bad++; $display("FAIL mc_eject_rep got=%0d exp=3", rc); end
        total++; if (ro !== 1'b0) begin bad++; $display("FAIL mc_eject_ready_idle got=%b exp=0", ro); end
        total++; if (vo_w !== 5'b10001) begin bad++; $display("FAIL mc_west_valid got=%b exp=10001", vo_w); end
        total++; if (rc_w !== 3'd2) begin bad++; $display("FAIL mc_west_rep got=%0d exp=2", rc_w); end
        total++; if (vo_n !== 5'b00001) begin bad++; $display("FAIL mc_north_valid got=%b exp=00001", vo_n); end
        rdy = 5'b11111;
        #1;
        total++; if (ro !== 1'b1) begin bad++; $display("FAIL mc_all_ready got=%b exp=1", ro); end
        total++; if (ro_w !== 1'b1) begin bad++; $display("FAIL mc_west_all_ready got=%b exp=1", ro_w); end
        next_cycle();
        valid = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_flit(3'd0, 3'd2, 3'd3, 3'd0, 1'b1, 1'b1, 16'h5555);
        valid = 1'b1;
        rdy   = 5'b00101;
        #3;
        total++; if (vo !== 5'b10101) begin bad++; $display("FAIL bp_c0_valid got=%b exp=10101", vo); end
        total++; if (ro !== 1'b0) begin bad++; $display("FAIL bp_c0_ready got=%b exp=0", ro); end
        next_cycle();
        #3;
        total++; if (vo !== 5'b10000) begin bad++; $display("FAIL bp_c1_valid got=%b exp=10000", vo); end
        total++; if (ro !== 1'b0) begin bad++; $display("FAIL bp_c1_ready got=%b exp=0", ro); end
        next_cycle();
        rdy = 5'b10101;
        #3;
        total++; if (vo !== 5'b10000) begin bad++; $display("FAIL bp_c2_valid got=%b exp=10000", vo); end
        total++; if (ro !== 1'b1) begin bad++; $display("FAIL bp_c2_ready got=%b exp=1", ro); end
        next_cycle();
        // Holding valid afterwards presents a fresh flit: all three outputs again
        rdy = 5'b00000;
        #3;
        total++; if (vo !== 5'b10101) begin bad++; $display("FAIL bp_sent_cleared got=%b exp=10101", vo); end
        valid = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_flit(3'd0, 3'd2, 3'd3, 3'd0, 1'b1, 1'b1, 16'h6666);
        valid = 1'b1;
        rdy   = 5'b00101;
        next_cycle();
        rdy = 5'b00000;
        #1;
        total++; if (vo !== 5'b10000) begin bad++; $display("FAIL ar_pre_valid got=%b exp=10000", vo); end
        #1;
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        total++; if (vo !== 5'b00000) begin bad++; $display("FAIL ar_in_reset_valid got=%b exp=00000", vo); end
        total++; if (ro !== 1'b0) begin bad++; $display("FAIL ar_in_reset_ready got=%b exp=0", ro); end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        valid = 1'b1;
        #3;
        total++; if (vo !== 5'b10101) begin bad++; $display("FAIL ar_refork_valid got=%b exp=10101", vo); end
        valid = 1'b0;
    endtask

    task automatic test_burst();
        apply_reset();
        rdy = 5'b11111;
        set_flit(3'd4, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0100);
        valid = 1'b1;
        #3;
        total++; if (rs !== 5'b10000) begin bad++; $display("FAIL burst_head_sel got=%b exp=10000", rs); end
        total++; if (ro !== 1'b1) begin bad++; $display("FAIL burst_head_ready got=%b exp=1", ro); end
        next_cycle();
        set_flit(3'd2, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0101);
        #3;
        total++; if (rs !== 5'b10000) begin bad++; $display("FAIL burst_body_sel got=%b exp=10000", rs); end
        total++; if (vo !== 5'b10000) begin bad++; $display("FAIL burst_body_valid got=%b exp=10000", vo); end
        next_cycle();
        set_flit(3'd2, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0102);
        #3;
        total++; if (rs !== 5'b10000) begin bad++; $display("FAIL burst_last_sel got=%b exp=10000", rs); end
        total++; if (ro !== 1'b1) begin bad++; $display("FAIL burst_last_ready got=%b exp=1", ro); end
        next_cycle();
        set_flit(3'd2, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0103);
        #3;
        total++; if (rs !== 5'b00001) begin bad++; $display("FAIL burst_after_sel got=%b exp=00001", rs); end
        next_cycle();
        valid = 1'b0;
        #3;
        total++; if (rs !== 5'b00000) begin bad++; $display("FAIL burst_idle_sel got=%b exp=00000", rs); end
    endtask

    task automatic test_empty();
        apply_reset();
        set_flit(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 1'b1, 16'h0E0E);
        valid = 1'b1;
        rdy   = 5'b00000;
        #3;
        total++; if (vo_n !== 5'b00000) begin bad++; $display("FAIL empty_valid got=%b exp=00000", vo_n); end
        total++; if (ro_n !== 1'b1) begin bad++; $display("FAIL empty_ready got=%b exp=1", ro_n); end
        total++; if (dr_n !== 1'b1) begin bad++; $display("FAIL empty_drop got=%b exp=1", dr_n); end
        total++; if (rc_n !== 3'd0) begin bad++; $display("FAIL empty_rep got=%0d exp=0", rc_n); end
        total++; if (vo !== 5'b00100) begin bad++; $display("FAIL empty_eject_inst_valid got=%b exp=00100", vo); end
        total++; if (dr !== 1'b0) begin bad++; $display("FAIL empty_eject_inst_drop got=%b exp=0", dr); end
        next_cycle();
        valid = 1'b0;
        #3;
        total++; if (dr_n !== 1'b0) begin bad++; $display("FAIL empty_drop_pulse got=%b exp=0", dr_n); end
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        rdy   = '0;
        xy    = '{x: 3'd2, y: 3'd2};
        chan  = '0;
        test_reset();
        test_unicast();
        test_mcast();
        test_backpressure();
        test_async_reset();
        test_burst();
        test_empty();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
